// File: rtl/div_unit_pkg.sv
// Shared widths, divider state encodings and handshake constants for the divide path.
package div_unit_pkg;

   localparam int RegBus       = 32;
   localparam int DoubleRegBus = 64;

   // Divider FSM states (2-bit encoding shared with execute-stage debug views).
   typedef enum logic [1:0] {
      DivFree   = 2'b00,
      DivByZero = 2'b01,
      DivOn     = 2'b10,
      DivEnd    = 2'b11
   } div_state_e;

   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;
   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;

   // ALU opcodes that route to the divider.
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface div_unit_if #(
   parameter int WIDTH = 32
);
   logic               signed_div_i;
   logic [WIDTH-1:0]   opdata1_i;
   logic [WIDTH-1:0]   opdata2_i;
   logic               start_i;
   logic               annul_i;
   logic [2*WIDTH-1:0] result_o;
   logic               ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = RegBus
)
(
   input logic       clk,
   input logic       rst,
   div_unit_if.slave bus
);

   localparam int               CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]    CNT_DONE = CW'(WIDTH);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

   // Two's complement negation when requested; used both for operand magnitude and result sign fix-up.
   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + ONE_W) : v;
   endfunction

   div_state_e         r_state,   w_state_next;
   logic [CW-1:0]      r_cnt,     w_cnt_next;
   logic [2*WIDTH:0]   r_dvd,     w_dvd_next;
   logic [WIDTH-1:0]   r_divisor, w_divisor_next;
   logic               r_signed,  w_signed_next;
   logic               r_sign1,   w_sign1_next;
   logic               r_sign2,   w_sign2_next;
   logic [2*WIDTH-1:0] r_result,  w_result_next;
   logic               r_ready,   w_ready_next;

   logic [WIDTH:0]     w_diff;
   logic [WIDTH-1:0]   w_abs1, w_abs2, w_quo, w_rem;

   // Trial subtraction of the divisor from the current partial remainder; bit WIDTH is the borrow.
   assign w_diff = {1'b0, r_dvd[2*WIDTH-1:WIDTH]} - {1'b0, r_divisor};
   assign w_abs1 = cond_neg(bus.opdata1_i, bus.signed_div_i & bus.opdata1_i[WIDTH-1]);
   assign w_abs2 = cond_neg(bus.opdata2_i, bus.signed_div_i & bus.opdata2_i[WIDTH-1]);
   // Quotient sign follows the operand signs; remainder takes the dividend's sign.
   assign w_quo  = cond_neg(r_dvd[WIDTH-1:0], r_signed & (r_sign1 ^ r_sign2));
   assign w_rem  = cond_neg(r_dvd[2*WIDTH:WIDTH+1], r_signed & r_sign1);

   assign bus.result_o = r_result;
   assign bus.ready_o  = r_ready;

   // State and datapath registers; reset returns to FREE with outputs cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= DivFree;
         r_cnt     <= '0;
         r_dvd     <= '0;
         r_divisor <= '0;
         r_signed  <= 1'b0;
         r_sign1   <= 1'b0;
         r_sign2   <= 1'b0;
         r_result  <= '0;
         r_ready   <= DivResultNotReady;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_dvd     <= w_dvd_next;
         r_divisor <= w_divisor_next;
         r_signed  <= w_signed_next;
         r_sign1   <= w_sign1_next;
         r_sign2   <= w_sign2_next;
         r_result  <= w_result_next;
         r_ready   <= w_ready_next;
      end
   end

   // Next-state and next-output logic: capture at start, one quotient bit per ON cycle, hold in END.
   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_dvd_next     = r_dvd;
      w_divisor_next = r_divisor;
      w_signed_next  = r_signed;
      w_sign1_next   = r_sign1;
      w_sign2_next   = r_sign2;
      w_result_next  = r_result;
      w_ready_next   = r_ready;

      case (r_state)
         DivFree: begin
            w_result_next = '0;
            w_ready_next  = DivResultNotReady;
            if (bus.start_i == DivStart && !bus.annul_i) begin
               w_signed_next = bus.signed_div_i;
               w_sign1_next  = bus.opdata1_i[WIDTH-1];
               w_sign2_next  = bus.opdata2_i[WIDTH-1];
               if (bus.opdata2_i == '0) begin
                  w_state_next = DivByZero;
               end else begin
                  w_dvd_next     = {{WIDTH{1'b0}}, w_abs1, 1'b0};
                  w_divisor_next = w_abs2;
                  w_cnt_next     = '0;
                  w_state_next   = DivOn;
               end
            end
         end
         DivByZero: begin
            w_result_next = '0;
            if (bus.annul_i) begin
               w_ready_next = DivResultNotReady;
               w_state_next = DivFree;
            end else begin
               w_ready_next = DivResultReady;
               w_state_next = DivEnd;
            end
         end
         DivOn: begin
            if (bus.annul_i) begin
               w_result_next = '0;
               w_ready_next  = DivResultNotReady;
               w_state_next  = DivFree;
            end else if (r_cnt != CNT_DONE) begin
               if (w_diff[WIDTH]) begin
                  w_dvd_next = {r_dvd[2*WIDTH-1:0], 1'b0};
               end else begin
                  w_dvd_next = {w_diff[WIDTH-1:0], r_dvd[WIDTH-1:0], 1'b1};
               end
               w_cnt_next = r_cnt + CNT_ONE;
            end else begin
               w_result_next = {w_rem, w_quo};
               w_ready_next  = DivResultReady;
               w_state_next  = DivEnd;
            end
         end
         DivEnd: begin
            if (bus.start_i == DivStop) begin
               w_result_next = '0;
               w_ready_next  = DivResultNotReady;
               w_state_next  = DivFree;
            end
         end
         default: begin
            w_state_next = DivFree;
         end
      endcase
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a monitor pops on each ready rise.
module tb_div_unit;

   logic clk = 1'b0;
   logic rst;

   div_unit_if #(.WIDTH(32)) bus ();

   div_unit #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [63:0] sb_q[$];

   // Reference: plain integer division; signed uses truncation toward zero, divide by zero gives 0.
   function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Monitor: compares each newly presented result against the oldest outstanding expectation.
   initial begin
      logic prev_ready;
      logic [63:0] exp;
      prev_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.ready_o && !prev_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_ready got result=%h required no ready", bus.result_o);
            end else begin
               exp = sb_q.pop_front();
               if (bus.result_o !== exp) begin
                  errors++;
                  $display("FAIL result got=%h required=%h", bus.result_o, exp);
               end
            end
         end
         prev_ready = bus.ready_o;
      end
   end

   // Full transaction: start held until ready, optional extra hold cycles, then start dropped.
   task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit scramble);
      logic [63:0] exp;
      int n, want;
      bit seen;
      exp = ref_div(s, a, b);
      sb_q.push_back(exp);
      bus.signed_div_i = s;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      n = 0;
      seen = 0;
      want = (b == 32'd0) ? 2 : 34;
      while (!seen && n < 100) begin
         @(posedge clk);
         n++;
         #1;
         if (bus.ready_o) seen = 1;
         else if (scramble) begin
            bus.opdata1_i    = $urandom;
            bus.opdata2_i    = $urandom;
            bus.signed_div_i = $urandom_range(0, 1);
         end
      end
      checks++;
      if (!seen || n != want) begin
         errors++;
         $display("FAIL latency got=%0d edges (seen=%0d) required=%0d", n, seen, want);
      end
      if (seen) begin
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (!bus.ready_o || bus.result_o !== exp) begin
               errors++;
               $display("FAIL hold ready=%0b result=%h required ready=1 result=%h",
                        bus.ready_o, bus.result_o, exp);
            end
         end
      end
      bus.start_i = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
         errors++;
         $display("FAIL release ready=%0b result=%h required ready=0 result=0",
                  bus.ready_o, bus.result_o);
      end
      $display("op signed=%0d a=%h b=%h expected=%h edges=%0d hold=%0d scramble=%0d",
               s, a, b, exp, n, hold, scramble);
   endtask

   // Aborted transaction: annul or reset after 'iters' ON edges; no result may ever appear.
   task automatic abort_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                           input int iters, input bit use_reset);
      int hits;
      bus.signed_div_i = s;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      bus.start_i      = 1'b1;
      repeat (iters + 1) @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      if (use_reset) rst = 1'b1;
      else bus.annul_i = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.annul_i = 1'b0;
      checks++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
         errors++;
         $display("FAIL abort_now ready=%0b result=%h required ready=0 result=0",
                  bus.ready_o, bus.result_o);
      end
      hits = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.ready_o) hits++;
      end
      checks++;
      if (hits != 0) begin
         errors++;
         $display("FAIL abort_quiet got ready for %0d cycles required 0", hits);
      end
      $display("abort signed=%0d a=%h b=%h at_iter=%0d by=%s", s, a, b, iters,
               use_reset ? "reset" : "annul");
   endtask

   initial begin
      logic [31:0] a, b;
      rst              = 1'b1;
      bus.signed_div_i = 1'b0;
      bus.opdata1_i    = '0;
      bus.opdata2_i    = '0;
      bus.start_i      = 1'b0;
      bus.annul_i      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
         errors++;
         $display("FAIL reset ready=%0b result=%h required ready=0 result=0",
                  bus.ready_o, bus.result_o);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_op(1'b0, 32'd100, 32'd7, 3, 1'b0);
      run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
      run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 1, 1'b0);
      run_op(1'b0, 32'd5, 32'd0, 2, 1'b0);
      run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
      abort_op(1'b0, 32'd1000, 32'd3, 10, 1'b0);
      run_op(1'b0, 32'hFFFF_FFFF, 32'h10, 0, 1'b0);
      abort_op(1'b1, 32'h1234_5678, 32'hFFFF_FF00, 20, 1'b1);
      run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
      run_op(1'b1, 32'hDEAD_BEEF, 32'h0000_0123, 0, 1'b1);
      run_op(1'b0, 32'd0, 32'd9, 0, 1'b0);

      for (int k = 0; k < 24; k++) begin
         case ($urandom_range(0, 3))
            0:       a = $urandom_range(0, 255);
            1:       a = 32'h8000_0000 | $urandom_range(0, 3);
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'hFFFF_FFFF;
            2, 3:    b = $urandom_range(1, 64);
            default: b = $urandom;
         endcase
         run_op(1'($urandom_range(0, 1)), a, b, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d outstanding required=0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
